// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Words narrower than 32 bits are zero-extended; padding zeros leave the parity unchanged.
  function automatic logic parity_calc(input logic [31:0] data, input int ptype);
    if (ptype == PARITY_ODD)  return ~^data;
    if (ptype == PARITY_EVEN) return ^data;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word handshake and error pulses of the UART receiver
interface uart_rx_if #(
  parameter int BITS_N = 8
) ();
  logic [BITS_N-1:0] data_rx;
  logic              valid;
  logic              ready;
  logic              framing_err;
  logic              parity_err;
  logic              overrun;

  modport master (output data_rx, valid, framing_err, parity_err, overrun, input ready);
  modport slave  (input data_rx, valid, framing_err, parity_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF line synchronizer (resets to idle-high) with falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_in,
  output logic rx_s,
  output logic fall
);
  logic s1, s2, s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= uart_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = s_prev & ~s2;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART frame receiver with valid/ready output; UART_RX_MAJORITY_EN enables 3-sample voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = PARITY_NONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  uart_rx_if.master  rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // With voting, every decision point moves one cycle later so bit spacing is preserved.
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(BITS_N - 1);

  uart_rx_state_t    state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [BW-1:0]     bit_n, bit_next;
  logic [BITS_N-1:0] shreg;
  logic              rx_s, fall, samp;
  logic              start_ok, take_data, take_par, take_stop;
  logic              done_q, stop_q, par_bad;
  logic              good, load;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_in (uart_in),
    .rx_s    (rx_s),
    .fall    (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic h0, h1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= 1'b1;
      h1 <= 1'b1;
    end else begin
      h0 <= rx_s;
      h1 <= h0;
    end
  end
  assign samp = (rx_s & h0) | (rx_s & h1) | (h0 & h1);
`else
  assign samp = rx_s;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_n;
    start_ok   = 1'b0;
    take_data  = 1'b0;
    take_par   = 1'b0;
    take_stop  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (fall) state_next = START_BIT;
      end
      START_BIT: begin
        if (cnt == HALF) begin
          cnt_next = '0;
          if (!samp) begin
            state_next = DATA_BITS;
            start_ok   = 1'b1;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA_BITS: begin
        if (cnt == FULL) begin
          cnt_next  = '0;
          take_data = 1'b1;
          bit_next  = bit_n + 1'b1;
          if (bit_n == LAST) begin
            bit_next   = '0;
            state_next = (PARITY_TYPE != PARITY_NONE) ? PARITY_BIT : STOP_BIT;
          end
        end
      end
      PARITY_BIT: begin
        if (cnt == FULL) begin
          cnt_next   = '0;
          take_par   = 1'b1;
          state_next = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (cnt == FULL) begin
          cnt_next   = '0;
          take_stop  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion runs one cycle after the stop sample, from the registered frame status.
  assign good = done_q & stop_q & ~par_bad;
  assign load = good & (~rx_if.valid | rx_if.ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_n             <= '0;
      shreg             <= '0;
      done_q            <= 1'b0;
      stop_q            <= 1'b0;
      par_bad           <= 1'b0;
      rx_if.data_rx     <= '0;
      rx_if.valid       <= 1'b0;
      rx_if.framing_err <= 1'b0;
      rx_if.parity_err  <= 1'b0;
      rx_if.overrun     <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      bit_n  <= bit_next;
      done_q <= take_stop;
      if (take_stop) stop_q <= samp;
      if (start_ok) par_bad <= 1'b0;
      if (take_par) par_bad <= (samp != parity_calc(32'(shreg), PARITY_TYPE));
      if (take_data) shreg[bit_n] <= samp;

      rx_if.framing_err <= done_q & ~stop_q;
      rx_if.parity_err  <= done_q & stop_q & par_bad;
      rx_if.overrun     <= good & rx_if.valid & ~rx_if.ready;
      if (load) begin
        rx_if.data_rx <= shreg;
        rx_if.valid   <= 1'b1;
      end else if (rx_if.valid && rx_if.ready) begin
        rx_if.valid   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx (no-parity and even-parity instances)
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1;
  logic line2 = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.BITS_N(8)) if0 ();
  uart_rx_if #(.BITS_N(8)) if2 ();

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(PARITY_NONE)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_in(line0), .rx_if(if0));
  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(PARITY_EVEN)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_in(line2), .rx_if(if2));

  int errors = 0;
  int checks = 0;
  int xfer0 = 0, vhi0 = 0, fe0 = 0, pe0 = 0, ov0 = 0;
  int xfer2 = 0, fe2 = 0, pe2 = 0, ov2 = 0;
  logic [7:0] last0 = '0;
  logic [7:0] last2 = '0;

  always @(negedge clk) begin
    if (if0.valid && if0.ready) begin
      xfer0 <= xfer0 + 1;
      last0 <= if0.data_rx;
    end
    if (if0.valid)       vhi0 <= vhi0 + 1;
    if (if0.framing_err) fe0  <= fe0 + 1;
    if (if0.parity_err)  pe0  <= pe0 + 1;
    if (if0.overrun)     ov0  <= ov0 + 1;
    if (if2.valid && if2.ready) begin
      xfer2 <= xfer2 + 1;
      last2 <= if2.data_rx;
    end
    if (if2.framing_err) fe2 <= fe2 + 1;
    if (if2.parity_err)  pe2 <= pe2 + 1;
    if (if2.overrun)     ov2 <= ov2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) line0 = v;
    else            line2 = v;
  endtask

  // One bit period; an optional 1-cycle inversion lands on the nominal mid-bit sample cycle.
  task automatic bit_per(input int which, input logic v, input bit spike);
    drive(which, v);
    tick(4);
    if (spike) drive(which, ~v);
    tick(1);
    drive(which, v);
    tick(3);
  endtask

  task automatic send(input int which, input logic [7:0] d, input bit par_en,
                      input logic par, input logic stop, input logic [7:0] spikes);
    bit_per(which, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_per(which, d[i], spikes[i]);
    if (par_en) bit_per(which, par, 1'b0);
    bit_per(which, stop, 1'b0);
    drive(which, 1'b1);
  endtask

  initial begin
    logic [7:0] spk;
`ifdef UART_RX_MAJORITY_EN
    spk = 8'h09;
`else
    spk = 8'h00;
`endif
    if0.ready = 1'b1;
    if2.ready = 1'b1;
    tick(3);
    chk("reset_valid0", 32'(if0.valid), 32'd0);
    chk("reset_data0", 32'(if0.data_rx), 32'd0);
    chk("reset_err0", 32'({if0.framing_err, if0.parity_err, if0.overrun}), 32'd0);
    chk("reset_valid2", 32'(if2.valid), 32'd0);
    rst_n = 1'b1;
    tick(5);

    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(12);
    chk("t1_xfer", 32'(xfer0), 32'd1);
    chk("t1_data", 32'(last0), 32'hA5);
    chk("t1_valid_cycles", 32'(vhi0), 32'd1);
    chk("t1_errs", 32'(fe0 + pe0 + ov0), 32'd0);

    line0 = 1'b0;
    tick(3);
    line0 = 1'b1;
    tick(20);
    chk("t2_xfer", 32'(xfer0), 32'd1);
    chk("t2_valid_cycles", 32'(vhi0), 32'd1);
    chk("t2_errs", 32'(fe0 + pe0 + ov0), 32'd0);

    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(12);
    chk("t3_framing", 32'(fe0), 32'd1);
    chk("t3_xfer", 32'(xfer0), 32'd1);
    chk("t3_valid_cycles", 32'(vhi0), 32'd1);
    chk("t3_parity", 32'(pe0), 32'd0);

    send(2, 8'h07, 1'b1, 1'b1, 1'b1, 8'h00);
    tick(12);
    chk("t4_good_xfer", 32'(xfer2), 32'd1);
    chk("t4_good_data", 32'(last2), 32'h07);
    chk("t4_good_errs", 32'(fe2 + pe2 + ov2), 32'd0);
    send(2, 8'h07, 1'b1, 1'b0, 1'b1, 8'h00);
    tick(12);
    chk("t4_parity_err", 32'(pe2), 32'd1);
    chk("t4_bad_xfer", 32'(xfer2), 32'd1);
    chk("t4_bad_framing", 32'(fe2), 32'd0);

    if0.ready = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(12);
    chk("t5_overrun", 32'(ov0), 32'd1);
    chk("t5_valid_held", 32'(if0.valid), 32'd1);
    chk("t5_data_held", 32'(if0.data_rx), 32'h11);
    chk("t5_no_xfer", 32'(xfer0), 32'd1);
    if0.ready = 1'b1;
    tick(2);
    chk("t5_xfer", 32'(xfer0), 32'd2);
    chk("t5_xfer_data", 32'(last0), 32'h11);
    chk("t5_valid_clear", 32'(if0.valid), 32'd0);
    tick(5);

    bit_per(0, 1'b0, 1'b0);
    bit_per(0, 1'b1, 1'b0);
    bit_per(0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("t6_reset_valid", 32'(if0.valid), 32'd0);
    line0 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1, spk);
    tick(12);
    chk("t6_xfer", 32'(xfer0), 32'd3);
    chk("t6_data", 32'(last0), 32'h81);
    chk("t6_framing", 32'(fe0), 32'd1);
    chk("t6_overrun", 32'(ov0), 32'd1);
    chk("t6_parity0", 32'(pe0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
